cic_dec_param: RTL
==================

Name: cic_dec_param

Overview:
Parametrised multi-stage CIC decimation filter. It generalises the team's fixed 5-stage / rate-12 decimator in stage count, differential delay, and output width. The decimation rate is programmable at run time, the comb pipeline is valid-tagged, and the output is rounded and saturated. It sits between the ADC/NCO sample stream and the downstream compensation FIR.

Parameters:
- N_STAGES, 5, number of integrator and comb stages (1..8).
- DIFF_DELAY, 2, comb differential delay M (1 or 2).
- INPUT_WIDTH, 15, signed input sample width.
- MAX_RATE, 16, largest decimation rate supported.
- RATE_WIDTH, 5, width of the rate port; must satisfy 2^RATE_WIDTH > MAX_RATE.
- ACC_WIDTH, 40, internal width; must equal INPUT_WIDTH + N_STAGES*ceil(log2(MAX_RATE*DIFF_DELAY)).
- OUTPUT_WIDTH, 40, output width (at most ACC_WIDTH); the top OUTPUT_WIDTH bits of the accumulator are kept.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of all filter state.
- rate  in  RATE_WIDTH  decimation rate R.
- nd  in  1  input sample valid.
- din  in  INPUT_WIDTH  signed input sample.
- dout  out  OUTPUT_WIDTH  signed output sample.
- rdy  out  1  one-cycle pulse marking dout valid.

Behaviour:
- Reset (rst_n low, asynchronous): all integrators, comb delay lines, the pipeline valid bits, the counter and rate_q are cleared; dout=0, rdy=0.
- clr high at a clock edge: same clearing as reset. Any in-flight comb samples are dropped and no rdy is produced for them. clr has priority over nd.
- Input: din is sign-extended to ACC_WIDTH. Integrator k updates only when nd is high: i_1 += din_ext, then i_k += i_(k-1) using the pre-update values. Arithmetic wraps modulo 2^ACC_WIDTH; wrap is intentional and cancels in the combs.
- Rate latch: rate_q loads on an nd cycle when cnt==0, i.e. at the start of each frame.
  - Values below 2 are clamped to 2; values above MAX_RATE are clamped to MAX_RATE.
  - A change on the rate port takes effect at the next frame boundary only. A frame in progress is never truncated.
- Decimation: cnt counts nd pulses from 0 to rate_q-1, then wraps to 0. On the nd that makes cnt==rate_q-1, the post-update value of i_N is captured into the comb pipeline with a valid bit.
- Comb chain, N_STAGES stages, each registered:
  - Stage k advances only when its input valid bit is set: c_k = x - x delayed by DIFF_DELAY samples.
  - Each stage keeps its own delay line, updated on the same valid.
  - Stages are independent, so back-to-back frames (R=2 with nd every cycle) are processed correctly.
- Output stage, applied when OUTPUT_WIDTH < ACC_WIDTH:
  - Round half up: add 2^(ACC_WIDTH-OUTPUT_WIDTH-1), then take the top bits.
  - If the rounding add overflows the positive maximum, saturate to 2^(OUTPUT_WIDTH-1)-1.
  - When OUTPUT_WIDTH==ACC_WIDTH, pass through unchanged.
- Latency: rdy rises exactly N_STAGES+2 clk cycles after the edge that samples the last nd of a frame. Latency is independent of later nd activity.
- dout: registered, holds its value between rdy pulses. rdy is high for exactly one cycle per frame.
- Gain: DC gain is (R*M)^N_STAGES. The first N_STAGES*DIFF_DELAY outputs after reset or clr are transient start-up values.

Test Plan:
- Default parameters, rate=12, din=+1 constant, nd every cycle -> after the transient, dout=24^5=7962624 on every rdy, and rdy is spaced 12 cycles apart.
- N_STAGES=3, DIFF_DELAY=1, rate=4, din=-1 constant with nd every 3rd cycle -> steady dout=-64. Each rdy occurs 5 cycles after the frame's 4th nd.
- rate changed from 4 to 8 mid-frame -> the current frame completes with 4 samples; the next frames use 8 samples; no rdy is lost or duplicated.
- rate=0 and rate=31 with MAX_RATE=16 -> behaves as R=2 and R=16 respectively (rdy every 2 and every 16 nd pulses).
- OUTPUT_WIDTH=24, din=+16383 constant, R=16, M=2 -> the rounded top 24 bits are checked against a reference model. Forcing a positive overflow on the rounding add yields 8388607.
- Assert rst_n low for 1 cycle, or clr high for 1 cycle, while a sample is in the comb pipeline -> dout=0, no rdy for the dropped sample, and the next frame restarts with cnt=0.

Source files
------------

// File: rtl/cic_dec_param.sv
// Multi-stage CIC decimator: wrapping integrators at the input rate, a
// valid-tagged comb chain at the frame rate, then round-half-up and saturate.
module cic_dec_param #(
  parameter int N_STAGES     = 5,
  parameter int DIFF_DELAY   = 2,
  parameter int INPUT_WIDTH  = 15,
  parameter int MAX_RATE     = 16,
  parameter int RATE_WIDTH   = 5,
  parameter int ACC_WIDTH    = 40,
  parameter int OUTPUT_WIDTH = 40
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic [RATE_WIDTH-1:0]          rate,
  input  logic                           nd,
  input  logic signed [INPUT_WIDTH-1:0]  din,
  output logic signed [OUTPUT_WIDTH-1:0] dout,
  output logic                           rdy
);

  localparam int SHIFT    = ACC_WIDTH - OUTPUT_WIDTH;
  localparam int HALF_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_WIDTH:0] HALF =
    (SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << HALF_POS) : (ACC_WIDTH+1)'(0);
  localparam logic [RATE_WIDTH-1:0] RATE_MIN = RATE_WIDTH'(2);
  localparam logic [RATE_WIDTH-1:0] RATE_MAX = RATE_WIDTH'(MAX_RATE);

  function automatic logic [RATE_WIDTH-1:0] clamp_rate(input logic [RATE_WIDTH-1:0] r);
    if (r < RATE_MIN) return RATE_MIN;
    if (r > RATE_MAX) return RATE_MAX;
    return r;
  endfunction

  // Returns the rounded value already shifted down, with one guard bit on top
  // so the saturation stage can see a positive overflow of the rounding add.
  function automatic logic signed [OUTPUT_WIDTH:0] round_top(input logic signed [ACC_WIDTH-1:0] x);
    logic signed [ACC_WIDTH:0] sum;
    sum = {x[ACC_WIDTH-1], x} + HALF;
    return sum[ACC_WIDTH -: OUTPUT_WIDTH+1];
  endfunction

  function automatic logic signed [OUTPUT_WIDTH-1:0] saturate(input logic signed [OUTPUT_WIDTH:0] s);
    if (s[OUTPUT_WIDTH] != s[OUTPUT_WIDTH-1]) return {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
    return s[OUTPUT_WIDTH-1:0];
  endfunction

  logic signed [ACC_WIDTH-1:0] din_ext;
  logic signed [ACC_WIDTH-1:0] integ     [N_STAGES];
  logic signed [ACC_WIDTH-1:0] integ_nxt [N_STAGES];
  logic [RATE_WIDTH-1:0]       cnt;
  logic [RATE_WIDTH-1:0]       rate_q;
  logic                        frame_last;

  logic signed [ACC_WIDTH-1:0] cap_p0;
  logic                        vld_p0;
  logic signed [ACC_WIDTH-1:0] comb_in  [N_STAGES];
  logic [N_STAGES-1:0]         comb_in_vld;
  logic signed [ACC_WIDTH-1:0] comb_q   [N_STAGES];
  logic [N_STAGES-1:0]         comb_vld;
  logic signed [ACC_WIDTH-1:0] dly      [N_STAGES][DIFF_DELAY];
  logic signed [OUTPUT_WIDTH:0] rnd_p1;
  logic                         vld_p1;

  assign din_ext    = {{(ACC_WIDTH-INPUT_WIDTH){din[INPUT_WIDTH-1]}}, din};
  assign frame_last = nd && (cnt == rate_q - RATE_WIDTH'(1));

  // Every integrator sees its predecessor's pre-update value.
  always_comb begin
    integ_nxt[0] = integ[0] + din_ext;
    for (int k = 1; k < N_STAGES; k++) integ_nxt[k] = integ[k] + integ[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_STAGES; k++) integ[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < N_STAGES; k++) integ[k] <= '0;
    end else if (nd) begin
      for (int k = 0; k < N_STAGES; k++) integ[k] <= integ_nxt[k];
    end
  end

  // p0: frame counter, rate latch at frame start, capture of the last integrator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      rate_q <= '0;
      cap_p0 <= '0;
      vld_p0 <= 1'b0;
    end else if (clr) begin
      cnt    <= '0;
      rate_q <= '0;
      cap_p0 <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= frame_last;
      if (frame_last) cap_p0 <= integ_nxt[N_STAGES-1];
      if (nd) begin
        if (cnt == '0) rate_q <= clamp_rate(rate);
        cnt <= frame_last ? '0 : cnt + RATE_WIDTH'(1);
      end
    end
  end

  always_comb begin
    comb_in[0]     = cap_p0;
    comb_in_vld[0] = vld_p0;
    for (int k = 1; k < N_STAGES; k++) begin
      comb_in[k]     = comb_q[k-1];
      comb_in_vld[k] = comb_vld[k-1];
    end
  end

  // comb stages: each advances and shifts its own delay line on its input valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comb_vld <= '0;
      for (int k = 0; k < N_STAGES; k++) begin
        comb_q[k] <= '0;
        for (int d = 0; d < DIFF_DELAY; d++) dly[k][d] <= '0;
      end
    end else if (clr) begin
      comb_vld <= '0;
      for (int k = 0; k < N_STAGES; k++) begin
        comb_q[k] <= '0;
        for (int d = 0; d < DIFF_DELAY; d++) dly[k][d] <= '0;
      end
    end else begin
      comb_vld <= comb_in_vld;
      for (int k = 0; k < N_STAGES; k++) begin
        if (comb_in_vld[k]) begin
          comb_q[k] <= comb_in[k] - dly[k][DIFF_DELAY-1];
          dly[k][0] <= comb_in[k];
          for (int d = 1; d < DIFF_DELAY; d++) dly[k][d] <= dly[k][d-1];
        end
      end
    end
  end

  // p1: rounding add; p2: saturation into the held output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_p1 <= '0;
      vld_p1 <= 1'b0;
      dout   <= '0;
      rdy    <= 1'b0;
    end else if (clr) begin
      rnd_p1 <= '0;
      vld_p1 <= 1'b0;
      dout   <= '0;
      rdy    <= 1'b0;
    end else begin
      vld_p1 <= comb_vld[N_STAGES-1];
      if (comb_vld[N_STAGES-1]) rnd_p1 <= round_top(comb_q[N_STAGES-1]);
      rdy <= vld_p1;
      if (vld_p1) dout <= saturate(rnd_p1);
    end
  end

endmodule
